// File: rtl/switch_bounce_emulator_if.sv
// Bundle of the command and observation signals of the switch bounce emulator.
// The master side (bench or stimulus logic) drives the command level and mode.
// The slave side (the emulator) returns the bouncing output and sequence status.
interface switch_bounce_emulator_if;
  logic enable;  // 1 = emulate bounce on command edges, 0 = pass cmd through
  logic cmd;     // clean target level
  logic noisy;   // emulated bouncing switch output
  logic busy;    // bounce sequence in progress
  logic done;    // one-cycle completion pulse

  modport master (
    output enable,
    output cmd,
    input  noisy,
    input  busy,
    input  done
  );

  modport slave (
    input  enable,
    input  cmd,
    output noisy,
    output busy,
    output done
  );
endinterface

// File: rtl/switch_bounce_emulator.sv
// Mechanical switch bounce emulator.
// Each accepted command edge drives the new level, then BOUNCES glitches back to
// the old level, each followed by a stable phase, and finally a one-cycle done.
// Every phase lasts D cycles; D = MIN_INTERVAL by default.
// Optional macro BOUNCE_RANDOM_EN: adds a 16-bit Galois LFSR (taps 16'hB400)
// that extends each phase by LFSR[RAND_BITS-1:0] cycles, sampled before the
// LFSR shifts. The LFSR advances once per phase load and holds otherwise.
// Reset is synchronous and active-high.
module switch_bounce_emulator #(
  parameter int unsigned BOUNCES      = 3,
  parameter int unsigned MIN_INTERVAL = 4,
  parameter int unsigned RAND_BITS    = 3,
  parameter int unsigned TW           = 16,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input logic                     clk,
  input logic                     reset,
  switch_bounce_emulator_if.slave bus
);

  // bounces_left must hold BOUNCES itself, and never be narrower than one bit.
  localparam int unsigned BW = (BOUNCES == 0) ? 1 : $clog2(BOUNCES + 1);
  localparam logic [BW-1:0] BOUNCES_INIT = BW'(BOUNCES);
  localparam logic [TW-1:0] MIN_M1       = TW'(MIN_INTERVAL - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStable,
    StGlitch
  } state_e;

  state_e        state_q;
  logic          level_q;
  logic          noisy_q;
  logic          done_q;
  logic [TW-1:0] timer_q;
  logic [BW-1:0] bounces_left_q;

  // Reload value (D - 1) for whichever phase is being started this cycle.
  logic [TW-1:0] phase_len_m1;

`ifdef BOUNCE_RANDOM_EN
  logic [15:0] lfsr_q;
  logic        phase_load;

  // Flags every cycle in which the FSM starts a new phase, so the LFSR steps once per phase.
  always_comb begin
    phase_load = 1'b0;
    case (state_q)
      StIdle:   phase_load = bus.enable && (bus.cmd != level_q);
      StStable: phase_load = (timer_q == '0) && (bounces_left_q != '0);
      StGlitch: phase_load = (timer_q == '0);
      default:  phase_load = 1'b0;
    endcase
  end

  // The random extension uses the LFSR value before this load's shift.
  assign phase_len_m1 = MIN_M1 + TW'(lfsr_q[RAND_BITS-1:0]);

  // Galois LFSR, shifted right with the tap mask folded in when bit 0 falls out.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (phase_load) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  logic unused_cfg;

  assign phase_len_m1 = MIN_M1;
  // Randomisation parameters have no effect in the deterministic build.
  assign unused_cfg   = (^SEED) ^ (RAND_BITS != 0);
`endif

  // Bounce sequencer: accepts command edges in idle and walks stable/glitch phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      level_q        <= 1'b0;
      noisy_q        <= 1'b0;
      done_q         <= 1'b0;
      timer_q        <= '0;
      bounces_left_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.cmd != level_q) begin
            noisy_q <= bus.cmd;
            level_q <= bus.cmd;
            // enable is only looked at here, so dropping it later cannot cut a sequence short.
            if (bus.enable) begin
              bounces_left_q <= BOUNCES_INIT;
              timer_q        <= phase_len_m1;
              state_q        <= StStable;
            end
          end
        end
        StStable: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (bounces_left_q != '0) begin
            noisy_q <= ~level_q;
            timer_q <= phase_len_m1;
            state_q <= StGlitch;
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        StGlitch: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            noisy_q        <= level_q;
            bounces_left_q <= bounces_left_q - BW'(1);
            timer_q        <= phase_len_m1;
            state_q        <= StStable;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.noisy = noisy_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Self-checking bench for switch_bounce_emulator.
// Three instances with different BOUNCES/MIN_INTERVAL share one stimulus stream.
// A sequence-level model (queue of expected output triples per instance) is
// checked every cycle; directed scenarios pin it with hand-computed literals.
module tb_switch_bounce_emulator;

  localparam int PB [3] = '{2, 0, 3};
  localparam int PM [3] = '{4, 1, 2};
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst;
  logic en;
  logic cmd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic model_on = 1'b0;

  switch_bounce_emulator_if if_a ();
  switch_bounce_emulator_if if_z ();
  switch_bounce_emulator_if if_r ();

  assign if_a.enable = en;
  assign if_a.cmd    = cmd;
  assign if_z.enable = en;
  assign if_z.cmd    = cmd;
  assign if_r.enable = en;
  assign if_r.cmd    = cmd;

  switch_bounce_emulator #(.BOUNCES(2), .MIN_INTERVAL(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (if_a)
  );

  switch_bounce_emulator #(.BOUNCES(0), .MIN_INTERVAL(1)) dut_z (
    .clk   (clk),
    .reset (rst),
    .bus   (if_z)
  );

  switch_bounce_emulator #(.BOUNCES(3), .MIN_INTERVAL(2), .RAND_BITS(3)) dut_r (
    .clk   (clk),
    .reset (rst),
    .bus   (if_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // {noisy, busy, done} of instance k
  function automatic logic [2:0] obs(input int k);
    case (k)
      0:       return {if_a.noisy, if_a.busy, if_a.done};
      1:       return {if_z.noisy, if_z.busy, if_z.done};
      default: return {if_r.noisy, if_r.busy, if_r.done};
    endcase
  endfunction

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: noisy/busy/done got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_level [3];
  logic [2:0] m_exp   [3];
  logic [2:0] m_q     [3][$];
  logic [15:0] m_lfsr [3];

  function automatic int next_len(input int k);
`ifdef BOUNCE_RANDOM_EN
    int r;
    r = int'(m_lfsr[k] % 16'd8);
    m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? 16'hB400 : 16'h0000);
    return PM[k] + r;
`else
    return PM[k];
`endif
  endfunction

  // One clock edge: a sequence is 2*B+1 phases alternating new/old level, then a done cycle.
  task automatic model_step(input int k);
    int   d;
    logic v;
    if (rst) begin
      m_level[k] = 1'b0;
      m_q[k].delete();
      m_exp[k]   = 3'b000;
      m_lfsr[k]  = SEED;
    end else if (m_q[k].size() != 0) begin
      m_exp[k] = m_q[k].pop_front();
    end else if (cmd != m_level[k]) begin
      m_level[k] = cmd;
      if (en) begin
        for (int p = 0; p < 2 * PB[k] + 1; p++) begin
          d = next_len(k);
          v = (p % 2 == 0) ? cmd : ~cmd;
          repeat (d) m_q[k].push_back({v, 1'b1, 1'b0});
        end
        m_q[k].push_back({cmd, 1'b0, 1'b1});
        m_exp[k] = m_q[k].pop_front();
      end else begin
        m_exp[k] = {cmd, 2'b00};
      end
    end else begin
      m_exp[k] = {m_level[k], 2'b00};
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  // Compare process: every instance, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== m_exp[k]) begin
          errors++;
          $display("FAIL model dut%0d cyc %0d: noisy/busy/done got %b expected %b",
                   k, cyc, obs(k), m_exp[k]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Plan waveform for BOUNCES=2, MIN_INTERVAL=4, j cycles after a rising command edge.
  function automatic logic pat(input int j);
    return (j <= 4) ? 1'b1 : (j <= 8) ? 1'b0 : (j <= 12) ? 1'b1 : (j <= 16) ? 1'b0 : 1'b1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((if_a.busy || if_z.busy || if_r.busy) && n < 500);
    chk("idle_timeout", int'(if_a.busy || if_z.busy || if_r.busy), 0);
    repeat (2) @(negedge clk);
  endtask

`ifdef BOUNCE_RANDOM_EN
  logic tr     [2][200];
  int   tr_len [2];

  task automatic run_trace(input int r);
    int n;
    rst = 1'b1;
    cmd = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmd = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      tr[r][n] = if_r.noisy;
      n++;
    end while (!if_r.done && n < 200);
    chk("trace_done_seen", int'(if_r.done), 1);
    tr_len[r] = n;
    wait_idle();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    cmd = 1'b0;
    repeat (2) @(negedge clk);
    model_on = 1'b1;
    chk3("reset_a", obs(0), 3'b000);
    chk3("reset_z", obs(1), 3'b000);
    chk3("reset_r", obs(2), 3'b000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifndef BOUNCE_RANDOM_EN
    // Rising edge with bounce: fixed glitch pattern, done at t+21.
    cmd = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      chk3("bounce_rise_a", obs(0), {pat(i), 1'(i <= 20), 1'(i == 21)});
      if (i <= 3) chk3("clean_rise_z", obs(1), {1'b1, 1'(i == 1), 1'(i == 2)});
    end
    wait_idle();

    // Passthrough with enable low, both directions.
    en  = 1'b0;
    cmd = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk3("pass_fall_a", obs(0), 3'b000);
    end
    cmd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk3("pass_rise_a", obs(0), 3'b100);
    end
    en = 1'b1;

    // BOUNCES=0, MIN_INTERVAL=1 falling edge: clean edge, done two cycles later.
    cmd = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk3("clean_fall_z", obs(1), {1'b0, 1'(i == 1), 1'(i == 2)});
    end
    wait_idle();

    // Command reverts mid-sequence: first sequence runs out, second starts after done.
    cmd = 1'b1;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      chk3("back_to_back_a", obs(0),
           {(i <= 21) ? pat(i) : ~pat(i - 21),
            1'((i <= 20) || (i >= 22 && i <= 41)),
            1'(i == 21 || i == 42)});
      if (i == 6) cmd = 1'b0;
    end
    wait_idle();

    // Reset mid-sequence aborts without done; the held command restarts a sequence.
    cmd = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 10) chk3("pre_reset_a", obs(0), {pat(i), 2'b10});
      if (i == 10) rst = 1'b1;
      if (i == 11) begin
        chk3("mid_reset_a", obs(0), 3'b000);
        rst = 1'b0;
      end
      if (i == 12) chk3("restart_a", obs(0), 3'b110);
    end
    wait_idle();
`else
    // Randomised phases: reproducible after reset, right toggle count, bounded lengths.
    begin
      int toggles;
      int start;
      int diffs;
      logic prev;
      int lens[$];
      run_trace(0);
      run_trace(1);
      chk("trace_len_repeat", tr_len[1], tr_len[0]);
      diffs = 0;
      for (int i = 0; i < tr_len[0] && i < tr_len[1]; i++) if (tr[0][i] != tr[1][i]) diffs++;
      chk("trace_repeat_diffs", diffs, 0);
      toggles = 0;
      start   = 0;
      prev    = 1'b0;
      for (int i = 0; i < tr_len[0] - 1; i++) begin
        if (tr[0][i] != prev) begin
          toggles++;
          if (i > 0) lens.push_back(i - start);
          start = i;
          prev  = tr[0][i];
        end
      end
      lens.push_back(tr_len[0] - 1 - start);
      chk("toggle_count_r", toggles, 7);
      chk("phase_count_r", lens.size(), 7);
      foreach (lens[p]) chk("phase_len_range_r", int'(lens[p] >= 2 && lens[p] <= 9), 1);
      chk("final_level_r", int'(tr[0][tr_len[0] - 1]), 1);
    end
`endif

    // Random stimulus, checked by the model compare process.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(11) == 0) cmd = ~cmd;
      if ($urandom_range(19) == 0) en = ~en;
      rst = ($urandom_range(299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
